// File: rtl/demux_1bit_1x8_sync.sv
// Registered 1-to-8 demultiplexer for a PWM gate bit. A channel switch is applied only on a carrier sync pulse.
// Optional dead-time blanking on a channel switch is enabled by defining DEMUX_BLANK_EN.
module demux_1bit_1x8_sync #(
    parameter int DEAD_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_0,
    input  logic [2:0] sel_0,
    input  logic       sel_valid,
    output logic       sel_ready,
    input  logic       sync_0,
    output logic [7:0] out_bus,
    output logic [2:0] active_sel_0
);

    typedef enum logic [1:0] {
        ROUTE = 2'd0,
        WAIT  = 2'd1,
        BREAK = 2'd2
    } state_t;

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYC - 1);

    state_t     state_reg, state_next;
    logic [2:0] active_reg, active_next;
    logic [2:0] pending_reg, pending_next;
    logic [7:0] count_reg, count_next;
    logic [7:0] out_reg, out_next;

    // One-hot images of in_0 on the current and on the requested channel.
    logic [7:0] route_active;
    logic [7:0] route_pending;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_route
            assign route_active[gi]  = in_0 && (active_reg == 3'(gi));
            assign route_pending[gi] = in_0 && (pending_reg == 3'(gi));
        end
    endgenerate

`ifndef DEMUX_BLANK_EN
    // Without blanking the dead-time length has no effect on the datapath.
    logic unused_dead_load;
    assign unused_dead_load = ^DEAD_LOAD;
`endif

    always_comb begin
        state_next   = state_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        count_next   = count_reg;
        out_next     = route_active;
        case (state_reg)
            ROUTE: begin
                // A sync pulse arriving with the request is deliberately not applied.
                if (sel_valid) begin
                    pending_next = sel_0;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (sync_0) begin
                    if (pending_reg == active_reg) begin
                        state_next = ROUTE;
                    end else begin
`ifdef DEMUX_BLANK_EN
                        state_next = BREAK;
                        count_next = DEAD_LOAD;
                        out_next   = '0;
`else
                        state_next  = ROUTE;
                        active_next = pending_reg;
                        out_next    = route_pending;
`endif
                    end
                end
            end
            BREAK: begin
                out_next = '0;
                if (count_reg == 8'd0) begin
                    state_next  = ROUTE;
                    active_next = pending_reg;
                    out_next    = route_pending;
                end else begin
                    count_next = count_reg - 8'd1;
                end
            end
            default: begin
                state_next = ROUTE;
                out_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ROUTE;
            active_reg  <= 3'd0;
            pending_reg <= 3'd0;
            count_reg   <= 8'd0;
            out_reg     <= 8'd0;
        end else begin
            state_reg   <= state_next;
            active_reg  <= active_next;
            pending_reg <= pending_next;
            count_reg   <= count_next;
            out_reg     <= out_next;
        end
    end

    assign sel_ready    = (state_reg == ROUTE);
    assign out_bus      = out_reg;
    assign active_sel_0 = active_reg;

endmodule

// File: tb/tb_demux_1bit_1x8_sync.sv
// Self-checking bench for demux_1bit_1x8_sync: an event-level model checked every cycle,
// plus directed scenarios with literal expectations. Expectations follow DEMUX_BLANK_EN.
module tb_demux_1bit_1x8_sync;

    localparam int DEAD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_0 = 1'b0;
    logic [2:0] sel_0 = 3'd0;
    logic       sel_valid = 1'b0;
    logic       sel_ready;
    logic       sync_0 = 1'b0;
    logic [7:0] out_bus;
    logic [2:0] active_sel_0;

    int checks = 0;
    int errors = 0;

    demux_1bit_1x8_sync #(.DEAD_CYC(DEAD)) dut (
        .clk(clk),
        .rst(rst),
        .in_0(in_0),
        .sel_0(sel_0),
        .sel_valid(sel_valid),
        .sel_ready(sel_ready),
        .sync_0(sync_0),
        .out_bus(out_bus),
        .active_sel_0(active_sel_0)
    );

    always #5 clk = ~clk;

    // Model: channel in use, requested channel (-1 = none) and zero cycles still owed.
    int         m_active = 0;
    int         m_pending = -1;
    int         m_blank = 0;
    logic [7:0] m_out = 8'h00;
    logic       m_ok = 1'b0;

    function automatic logic [7:0] onto(input logic b, input int ch);
        logic [7:0] v;
        v = 8'h00;
        v[ch] = b;
        return v;
    endfunction

    always @(posedge clk) begin
        automatic int act = m_active;
        automatic int pend = m_pending;
        automatic int blank = m_blank;
        automatic logic [7:0] o = onto(in_0, m_active);
        if (rst) begin
            act = 0; pend = -1; blank = 0; o = 8'h00;
        end else if (blank > 0) begin
            blank = blank - 1;
            if (blank == 0) begin
                act = pend; pend = -1; o = onto(in_0, act);
            end else begin
                o = 8'h00;
            end
        end else if (pend >= 0) begin
            if (sync_0) begin
                if (pend == act) begin
                    pend = -1;
                end else begin
`ifdef DEMUX_BLANK_EN
                    blank = DEAD; o = 8'h00;
`else
                    act = pend; pend = -1; o = onto(in_0, act);
`endif
                end
            end
        end else if (sel_valid) begin
            pend = int'(sel_0);
        end
        m_active  <= act;
        m_pending <= pend;
        m_blank   <= blank;
        m_out     <= o;
        if (rst) m_ok <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            check("model_out_bus", 32'(out_bus), 32'(m_out));
            check("model_sel_ready", 32'(sel_ready), 32'(m_pending < 0));
            check("model_active_sel", 32'(active_sel_0), 32'(m_active));
            check("one_hot_out", 32'($countones(out_bus) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic request(input logic [2:0] ch);
        sel_0 = ch;
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic pulse_sync();
        sync_0 = 1'b1;
        tick();
        sync_0 = 1'b0;
    endtask

    initial begin
        // Reset for two cycles, then route channel 0.
        rst = 1'b1;
        tick();
        check("rst_out", 32'(out_bus), 32'h00);
        check("rst_ready", 32'(sel_ready), 32'd1);
        check("rst_active", 32'(active_sel_0), 32'd0);
        tick();
        check("rst_out_2", 32'(out_bus), 32'h00);
        rst = 1'b0;
        in_0 = 1'b1;
        tick();
        check("first_route", 32'(out_bus), 32'h01);
        $display("step reset_release out_bus=%02h", out_bus);

        // Switch 0 -> 3.
        request(3'd3);
        check("wait_ready", 32'(sel_ready), 32'd0);
        check("wait_old_route", 32'(out_bus), 32'h01);
        pulse_sync();
`ifdef DEMUX_BLANK_EN
        check("blank_0", 32'(out_bus), 32'h00);
        for (int i = 1; i < DEAD; i++) begin
            tick();
            check("blank_n", 32'(out_bus), 32'h00);
        end
        check("blank_ready", 32'(sel_ready), 32'd0);
        tick();
`endif
        check("switch3_out", 32'(out_bus), 32'h08);
        check("switch3_ready", 32'(sel_ready), 32'd1);
        check("switch3_active", 32'(active_sel_0), 32'd3);
        $display("step switch_to_3 out_bus=%02h", out_bus);

        // Same-channel request: no blanking.
        request(3'd3);
        pulse_sync();
        check("same_out", 32'(out_bus), 32'h08);
        check("same_ready", 32'(sel_ready), 32'd1);
        $display("step same_channel out_bus=%02h", out_bus);

        // Request coinciding with sync; only the later sync switches.
        sel_0 = 3'd5; sel_valid = 1'b1; sync_0 = 1'b1;
        tick();
        sel_valid = 1'b0; sync_0 = 1'b0;
        check("coinc_ready", 32'(sel_ready), 32'd0);
        for (int i = 0; i < 9; i++) tick();
        check("coinc_hold_out", 32'(out_bus), 32'h08);
        check("coinc_hold_active", 32'(active_sel_0), 32'd3);
        pulse_sync();
`ifdef DEMUX_BLANK_EN
        check("coinc_blank", 32'(out_bus), 32'h00);
        for (int i = 0; i < DEAD; i++) tick();
`endif
        check("coinc_switch", 32'(out_bus), 32'h20);
        $display("step coincident_sync out_bus=%02h", out_bus);

        // Reset while a switch is pending (mid-blank when blanking is on).
        request(3'd1);
`ifdef DEMUX_BLANK_EN
        pulse_sync();
        tick();
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out", 32'(out_bus), 32'h00);
        check("midrst_active", 32'(active_sel_0), 32'd0);
        check("midrst_ready", 32'(sel_ready), 32'd1);
        tick();
        check("after_rst_route", 32'(out_bus), 32'h01);
        tick();
        check("after_rst_noblank", 32'(out_bus), 32'h01);
        $display("step reset_mid_switch out_bus=%02h", out_bus);

        // Switch 0 -> 7.
        request(3'd7);
        pulse_sync();
`ifdef DEMUX_BLANK_EN
        for (int i = 0; i < DEAD; i++) tick();
`endif
        check("switch7_out", 32'(out_bus), 32'h80);
        $display("step switch_to_7 out_bus=%02h", out_bus);

        // Random toggling, checked by the model every cycle.
        for (int i = 0; i < 400; i++) begin
            in_0      = 1'($urandom_range(0, 1));
            sel_0     = 3'($urandom_range(0, 7));
            sel_valid = ($urandom_range(0, 3) == 0);
            sync_0    = ($urandom_range(0, 4) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; sel_valid = 1'b0; sync_0 = 1'b0;
        tick();
        $display("step random_run cycles=400");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1bit_1x8_sync.md
DEMUX_1BIT_1X8_SYNC -- requirements
Module: demux_1bit_1x8_sync

Interface
REQ-001 The module SHALL have parameter DEAD_CYC, default 8, giving the number of blanking cycles on a channel switch (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_0  input  1  single-bit source (PWM gate signal) to be routed.
REQ-005 sel_0  input  3  requested destination channel 0..7.
REQ-006 sel_valid  input  1  request strobe; sel_0 is captured when sel_valid and sel_ready are both high.
REQ-007 sel_ready  output  1  high when a new select request can be accepted.
REQ-008 sync_0  input  1  one-cycle carrier-boundary pulse; a pending switch is applied only here.
REQ-009 out_bus  output  8  registered routed outputs; bit k is channel k.
REQ-010 active_sel_0  output  3  channel currently routed.

Function
REQ-011 out_bus SHALL be fully registered: in the ROUTE state, out_bus[active_sel_0] equals in_0 sampled one cycle earlier, and all other bits are 0.
REQ-012 At most one bit of out_bus SHALL be high in any cycle.
REQ-013 The FSM SHALL have exactly three states: ROUTE, WAIT and BREAK.
REQ-014 In ROUTE, sel_ready = 1, and a handshake SHALL capture sel_0 into pending_sel and move the FSM to WAIT with sel_ready = 0 on the next cycle.
REQ-015 In WAIT, routing SHALL continue on the old channel, and sync_0 low SHALL keep the FSM in WAIT.
REQ-016 In WAIT with sync_0 high and pending_sel == active_sel_0, the FSM SHALL return to ROUTE, set sel_ready = 1 next cycle, and insert no blanking.
REQ-017 In WAIT with sync_0 high and pending_sel != active_sel_0, the FSM SHALL enter BREAK, load the counter with DEAD_CYC-1, and register out_bus = 0.
REQ-018 In BREAK, out_bus SHALL be 0 and the counter SHALL decrement each cycle.
REQ-019 In BREAK with counter == 0, the FSM SHALL set active_sel_0 = pending_sel, register in_0 onto the new channel, return to ROUTE and set sel_ready = 1; this gives exactly DEAD_CYC visible all-zero cycles.
REQ-020 When sel_valid and sync_0 are high in the same ROUTE cycle, the handshake SHALL be taken and that sync_0 SHALL NOT apply the switch; the switch waits for the next sync_0.
REQ-021 sync_0 SHALL be ignored in ROUTE and BREAK, and sel_valid SHALL be ignored while sel_ready = 0.
REQ-022 The counter SHALL be 8 bits wide and SHALL never underflow.

Reset
REQ-023 While rst is high at a clock edge: state = ROUTE, active_sel_0 = 0, pending_sel = 0, counter = 0, out_bus = 0, sel_ready = 1.
REQ-024 Reset asserted in WAIT or BREAK SHALL discard the pending request, with no further blanking after reset.
REQ-025 In the first cycle after rst falls, routing to channel 0 SHALL begin (out_bus[0] reflects in_0 one cycle later).

Configuration
REQ-026 Macro DEMUX_BLANK_EN, when defined, SHALL enable the BREAK state and the behaviour of REQ-017 to REQ-019.
REQ-027 When DEMUX_BLANK_EN is undefined, sync_0 in WAIT with a differing pending_sel SHALL update active_sel_0 and route in_0 onto the new channel in the same edge, with no zero cycles; sel_ready SHALL be 1 the next cycle; DEAD_CYC is unused and BREAK is unreachable.

Verification
REQ-028 rst high 2 cycles, then low -> out_bus = 8'h00 during reset, sel_ready = 1, active_sel_0 = 0; in_0 = 1 gives out_bus = 8'h01 one cycle later.
REQ-029 Request sel_0 = 3 with sync_0 at cycle t, macro on, DEAD_CYC = 4, in_0 = 1 -> out_bus = 8'h01 up to t, 8'h00 for t+1..t+4, 8'h08 at t+5; sel_ready = 1 at t+5.
REQ-030 Request sel_0 equal to active_sel_0, then sync_0 -> no zero cycle on out_bus; sel_ready returns to 1 one cycle after sync_0.
REQ-031 sel_valid and sync_0 in the same ROUTE cycle, then a second sync_0 10 cycles later -> the switch starts only at the second sync_0.
REQ-032 rst asserted at BREAK count 2 -> out_bus = 8'h00 and active_sel_0 = 0 next cycle; sel_ready = 1.
REQ-033 Macro off, switch 0 -> 7 with sync_0 at t, in_0 = 1 -> out_bus = 8'h01 at t, 8'h80 at t+1; a random-toggle run SHALL never show more than one bit set in out_bus.
